// File: rtl/ts_mixer_if.sv
// Sample-strobe, PSG/FM inputs and mixed-output bundle for ts_mixer.
interface ts_mixer_if;
    logic               CE;
    logic [7:0]         SSG0_AUDIO_A;
    logic [7:0]         SSG0_AUDIO_B;
    logic [7:0]         SSG0_AUDIO_C;
    logic [7:0]         SSG1_AUDIO_A;
    logic [7:0]         SSG1_AUDIO_B;
    logic [7:0]         SSG1_AUDIO_C;
    logic signed [15:0] SSG0_AUDIO_FM;
    logic signed [15:0] SSG1_AUDIO_FM;
    logic               SSG_FM_ENA;
    logic [1:0]         STEREO;
    logic signed [15:0] AUDIO_L;
    logic signed [15:0] AUDIO_R;
    logic               AUDIO_VALID;
    logic               OVERRUN;

    modport master (
        output CE, SSG0_AUDIO_A, SSG0_AUDIO_B, SSG0_AUDIO_C,
        output SSG1_AUDIO_A, SSG1_AUDIO_B, SSG1_AUDIO_C,
        output SSG0_AUDIO_FM, SSG1_AUDIO_FM, SSG_FM_ENA, STEREO,
        input  AUDIO_L, AUDIO_R, AUDIO_VALID, OVERRUN
    );

    modport slave (
        input  CE, SSG0_AUDIO_A, SSG0_AUDIO_B, SSG0_AUDIO_C,
        input  SSG1_AUDIO_A, SSG1_AUDIO_B, SSG1_AUDIO_C,
        input  SSG0_AUDIO_FM, SSG1_AUDIO_FM, SSG_FM_ENA, STEREO,
        output AUDIO_L, AUDIO_R, AUDIO_VALID, OVERRUN
    );
endinterface

// File: rtl/ts_mixer.sv
// Dual PSG + FM serial stereo mixer, one term per clock, saturated output.
// Define TS_MIXER_FM_EN to include the two FM accumulation steps.
module ts_mixer (
    input logic       CLK,
    input logic       RESET,
    ts_mixer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

`ifdef TS_MIXER_FM_EN
    localparam logic [2:0] LAST = 3'd7;
`else
    localparam logic [2:0] LAST = 3'd5;
`endif

    state_t             state;
    state_t             state_nx;
    logic [2:0]         step;
    logic signed [17:0] acc_l;
    logic signed [17:0] acc_r;
    logic signed [17:0] term_l;
    logic signed [17:0] term_r;
    logic [7:0]         snap [6];
    logic [1:0]         snap_stereo;
    logic signed [15:0] audio_l;
    logic signed [15:0] audio_r;
    logic               audio_valid;
    logic               overrun;
    logic [7:0]         lvl;
    logic [1:0]         chan;
    logic [17:0]        full;
    logic [17:0]        half;
    logic               mono;
    logic               acb;

`ifdef TS_MIXER_FM_EN
    logic signed [15:0] snap_fm0;
    logic signed [15:0] snap_fm1;
    logic               snap_fm_ena;
    logic signed [17:0] fm_ext;
    logic               fm_step;
`else
    logic               unused_fm;
    assign unused_fm = ^{bus.SSG0_AUDIO_FM, bus.SSG1_AUDIO_FM,
                         bus.SSG_FM_ENA};
`endif

    assign bus.AUDIO_L     = audio_l;
    assign bus.AUDIO_R     = audio_r;
    assign bus.AUDIO_VALID = audio_valid;
    assign bus.OVERRUN     = overrun;

    function automatic logic signed [15:0] sat(input logic signed [17:0] v);
        if (v > 18'sd32767)
            return 16'sh7FFF;
        else if (v < -18'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.CE) state_nx = ACC;
            ACC:     if (step == LAST) state_nx = OUT;
            OUT:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Step order A0,B0,C0,A1,B1,C1 maps to channel step mod 3.
    always_comb begin
        lvl  = 8'd0;
        chan = 2'd0;
        case (step)
            3'd0: begin lvl = snap[0]; chan = 2'd0; end
            3'd1: begin lvl = snap[1]; chan = 2'd1; end
            3'd2: begin lvl = snap[2]; chan = 2'd2; end
            3'd3: begin lvl = snap[3]; chan = 2'd0; end
            3'd4: begin lvl = snap[4]; chan = 2'd1; end
            3'd5: begin lvl = snap[5]; chan = 2'd2; end
            default: begin lvl = 8'd0; chan = 2'd0; end
        endcase
    end

    assign full = {6'd0, lvl, 4'd0};
    assign half = {7'd0, lvl, 3'd0};
    assign mono = (snap_stereo == 2'b00);
    assign acb  = (snap_stereo == 2'b10);

`ifdef TS_MIXER_FM_EN
    assign fm_step = (step[2:1] == 2'b11);
    assign fm_ext  = step[0] ? {{2{snap_fm1[15]}}, snap_fm1}
                             : {{2{snap_fm0[15]}}, snap_fm0};
`endif

    always_comb begin
        term_l = '0;
        term_r = '0;
`ifdef TS_MIXER_FM_EN
        if (fm_step) begin
            if (snap_fm_ena) begin
                term_l = fm_ext >>> 1;
                term_r = fm_ext >>> 1;
            end
        end else
`endif
        if (mono) begin
            term_l = $signed(half);
            term_r = $signed(half);
        end else begin
            case (chan)
                2'd0: term_l = $signed(full);
                2'd1: begin
                    if (acb) begin
                        term_r = $signed(full);
                    end else begin
                        term_l = $signed(half);
                        term_r = $signed(half);
                    end
                end
                default: begin
                    if (acb) begin
                        term_l = $signed(half);
                        term_r = $signed(half);
                    end else begin
                        term_r = $signed(full);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            step        <= '0;
            acc_l       <= '0;
            acc_r       <= '0;
            audio_l     <= '0;
            audio_r     <= '0;
            audio_valid <= 1'b0;
            overrun     <= 1'b0;
            snap_stereo <= '0;
            for (int i = 0; i < 6; i++)
                snap[i] <= '0;
`ifdef TS_MIXER_FM_EN
            snap_fm0    <= '0;
            snap_fm1    <= '0;
            snap_fm_ena <= 1'b0;
`endif
        end else begin
            audio_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.CE) begin
                        snap[0]     <= bus.SSG0_AUDIO_A;
                        snap[1]     <= bus.SSG0_AUDIO_B;
                        snap[2]     <= bus.SSG0_AUDIO_C;
                        snap[3]     <= bus.SSG1_AUDIO_A;
                        snap[4]     <= bus.SSG1_AUDIO_B;
                        snap[5]     <= bus.SSG1_AUDIO_C;
                        snap_stereo <= bus.STEREO;
`ifdef TS_MIXER_FM_EN
                        snap_fm0    <= bus.SSG0_AUDIO_FM;
                        snap_fm1    <= bus.SSG1_AUDIO_FM;
                        snap_fm_ena <= bus.SSG_FM_ENA;
`endif
                        acc_l       <= '0;
                        acc_r       <= '0;
                        step        <= '0;
                    end
                end
                ACC: begin
                    acc_l <= acc_l + term_l;
                    acc_r <= acc_r + term_r;
                    step  <= (step == LAST) ? 3'd0 : step + 3'd1;
                    if (bus.CE)
                        overrun <= 1'b1;
                end
                OUT: begin
                    audio_l     <= sat(acc_l);
                    audio_r     <= sat(acc_r);
                    audio_valid <= 1'b1;
                    if (bus.CE)
                        overrun <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ts_mixer.sv
// Directed checks of ts_mixer routing, FM, saturation, latency and overrun.
module tb_ts_mixer;

`ifdef TS_MIXER_FM_EN
    localparam int  LAT   = 9;
    localparam bit  HASFM = 1'b1;
`else
    localparam int  LAT   = 7;
    localparam bit  HASFM = 1'b0;
`endif

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    ts_mixer_if bus ();

    ts_mixer dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_in(input logic [7:0] a0, b0, c0, a1, b1, c1,
                          input logic [15:0] fm0, fm1,
                          input logic ena, input logic [1:0] st);
        bus.SSG0_AUDIO_A  = a0;
        bus.SSG0_AUDIO_B  = b0;
        bus.SSG0_AUDIO_C  = c0;
        bus.SSG1_AUDIO_A  = a1;
        bus.SSG1_AUDIO_B  = b1;
        bus.SSG1_AUDIO_C  = c1;
        bus.SSG0_AUDIO_FM = fm0;
        bus.SSG1_AUDIO_FM = fm1;
        bus.SSG_FM_ENA    = ena;
        bus.STEREO        = st;
    endtask

    // Called 1ns after an edge; CE is sampled on the next edge.
    task automatic fire_ce();
        bus.CE = 1'b1;
        @(posedge clk);
        #1;
        bus.CE = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.AUDIO_VALID) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.CE = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01);
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (bus.AUDIO_L !== 16'sd0) begin
            miscompares++;
            $display("FAIL reset_l got %0d want 0", bus.AUDIO_L);
        end
        vectors++;
        if (bus.AUDIO_R !== 16'sd0) begin
            miscompares++;
            $display("FAIL reset_r got %0d want 0", bus.AUDIO_R);
        end
        vectors++;
        if (bus.AUDIO_VALID !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valid got %b want 0", bus.AUDIO_VALID);
        end
        vectors++;
        if (bus.OVERRUN !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_overrun got %b want 0", bus.OVERRUN);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_abc_a0();
        int lat;
        set_in(8'hFF, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01);
        fire_ce();
        wait_valid(lat);
        vectors++;
        if (lat !== LAT) begin
            miscompares++;
            $display("FAIL abc_a0_latency got %0d want %0d", lat, LAT);
        end
        vectors++;
        if (bus.AUDIO_L !== 16'sd4080 || bus.AUDIO_R !== 16'sd0) begin
            miscompares++;
            $display("FAIL abc_a0 got L=%0d R=%0d want L=4080 R=0",
                     bus.AUDIO_L, bus.AUDIO_R);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (bus.AUDIO_VALID !== 1'b0) begin
            miscompares++;
            $display("FAIL valid_pulse_width got %b want 0", bus.AUDIO_VALID);
        end
    endtask

    task automatic test_routing();
        int lat;
        set_in(0, 8'h80, 0, 0, 0, 0, 0, 0, 0, 2'b01);
        fire_ce();
        wait_valid(lat);
        vectors++;
        if (lat !== LAT || bus.AUDIO_L !== 16'sd1024 ||
            bus.AUDIO_R !== 16'sd1024) begin
            miscompares++;
            $display("FAIL abc_b0 got lat=%0d L=%0d R=%0d want %0d 1024 1024",
                     lat, bus.AUDIO_L, bus.AUDIO_R, LAT);
        end
        set_in(8'h10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        fire_ce();
        wait_valid(lat);
        vectors++;
        if (lat !== LAT || bus.AUDIO_L !== 16'sd128 ||
            bus.AUDIO_R !== 16'sd128) begin
            miscompares++;
            $display("FAIL mono_a0 got lat=%0d L=%0d R=%0d want %0d 128 128",
                     lat, bus.AUDIO_L, bus.AUDIO_R, LAT);
        end
        // A0 full 16 + C0 half 32 + A1 full 256 ; B0 full 32 + C0 half 32
        set_in(8'h01, 8'h02, 8'h04, 8'h10, 0, 0, 0, 0, 0, 2'b10);
        fire_ce();
        wait_valid(lat);
        vectors++;
        if (lat !== LAT || bus.AUDIO_L !== 16'sd304 ||
            bus.AUDIO_R !== 16'sd64) begin
            miscompares++;
            $display("FAIL acb_mix got lat=%0d L=%0d R=%0d want %0d 304 64",
                     lat, bus.AUDIO_L, bus.AUDIO_R, LAT);
        end
        set_in(0, 0, 0, 0, 0, 8'h20, 0, 0, 0, 2'b11);
        fire_ce();
        wait_valid(lat);
        vectors++;
        if (lat !== LAT || bus.AUDIO_L !== 16'sd0 ||
            bus.AUDIO_R !== 16'sd512) begin
            miscompares++;
            $display("FAIL stereo11_c1 got lat=%0d L=%0d R=%0d want %0d 0 512",
                     lat, bus.AUDIO_L, bus.AUDIO_R, LAT);
        end
    endtask

    task automatic test_fm();
        int lat;
        logic signed [15:0] el;
        logic signed [15:0] er;
        el = HASFM ? 16'sh7FFF : 16'sd8160;
        er = HASFM ? 16'sh7FFE : 16'sd0;
        set_in(8'hFF, 0, 0, 8'hFF, 0, 0, 16'h7FFF, 16'h7FFF, 1'b1, 2'b01);
        fire_ce();
        wait_valid(lat);
        vectors++;
        if (lat !== LAT || bus.AUDIO_L !== el || bus.AUDIO_R !== er) begin
            miscompares++;
            $display("FAIL fm_pos_sat got lat=%0d L=%0d R=%0d want %0d %0d %0d",
                     lat, bus.AUDIO_L, bus.AUDIO_R, LAT, el, er);
        end
        el = HASFM ? 16'sh8000 : 16'sd0;
        set_in(0, 0, 0, 0, 0, 0, 16'h8000, 16'h8000, 1'b1, 2'b01);
        fire_ce();
        wait_valid(lat);
        vectors++;
        if (lat !== LAT || bus.AUDIO_L !== el || bus.AUDIO_R !== el) begin
            miscompares++;
            $display("FAIL fm_neg got lat=%0d L=%0d R=%0d want %0d %0d %0d",
                     lat, bus.AUDIO_L, bus.AUDIO_R, LAT, el, el);
        end
        set_in(0, 0, 0, 0, 0, 0, 16'h8000, 16'h8000, 1'b0, 2'b01);
        fire_ce();
        wait_valid(lat);
        vectors++;
        if (lat !== LAT || bus.AUDIO_L !== 16'sd0 || bus.AUDIO_R !== 16'sd0) begin
            miscompares++;
            $display("FAIL fm_disabled got lat=%0d L=%0d R=%0d want %0d 0 0",
                     lat, bus.AUDIO_L, bus.AUDIO_R, LAT);
        end
    endtask

    task automatic test_snapshot_hold();
        int lat;
        set_in(8'h01, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01);
        fire_ce();
        set_in(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
               16'h7FFF, 16'h7FFF, 1'b1, 2'b00);
        wait_valid(lat);
        vectors++;
        if (lat !== LAT || bus.AUDIO_L !== 16'sd16 || bus.AUDIO_R !== 16'sd0) begin
            miscompares++;
            $display("FAIL snapshot got lat=%0d L=%0d R=%0d want %0d 16 0",
                     lat, bus.AUDIO_L, bus.AUDIO_R, LAT);
        end
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if (bus.AUDIO_L !== 16'sd16 || bus.AUDIO_R !== 16'sd0) begin
            miscompares++;
            $display("FAIL hold got L=%0d R=%0d want 16 0",
                     bus.AUDIO_L, bus.AUDIO_R);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        set_in(0, 0, 8'h01, 0, 0, 0, 0, 0, 0, 2'b01);
        fire_ce();
        wait_valid(lat);
        set_in(0, 0, 8'h02, 0, 0, 0, 0, 0, 0, 2'b01);
        fire_ce();
        wait_valid(lat);
        vectors++;
        if (lat !== LAT || bus.AUDIO_R !== 16'sd32 || bus.AUDIO_L !== 16'sd0) begin
            miscompares++;
            $display("FAIL back_to_back got lat=%0d L=%0d R=%0d want %0d 0 32",
                     lat, bus.AUDIO_L, bus.AUDIO_R, LAT);
        end
        vectors++;
        if (bus.OVERRUN !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_no_overrun got %b want 0", bus.OVERRUN);
        end
    endtask

    task automatic test_overrun();
        int pulses;
        int first;
        set_in(8'h02, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01);
        fire_ce();
        repeat (3) @(posedge clk);
        #1;
        set_in(8'h40, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01);
        fire_ce();
        pulses = 0;
        first  = -1;
        for (int i = 5; i < 5 + 14; i++) begin
            @(posedge clk);
            #1;
            if (bus.AUDIO_VALID) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        vectors++;
        if (pulses !== 1 || first !== LAT) begin
            miscompares++;
            $display("FAIL overrun_single_valid got pulses=%0d at=%0d want 1 at %0d",
                     pulses, first, LAT);
        end
        vectors++;
        if (bus.AUDIO_L !== 16'sd32 || bus.AUDIO_R !== 16'sd0) begin
            miscompares++;
            $display("FAIL overrun_result got L=%0d R=%0d want 32 0",
                     bus.AUDIO_L, bus.AUDIO_R);
        end
        vectors++;
        if (bus.OVERRUN !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_flag got %b want 1", bus.OVERRUN);
        end
        fire_ce();
        wait_valid(first);
        vectors++;
        if (bus.OVERRUN !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_sticky got %b want 1", bus.OVERRUN);
        end
    endtask

    task automatic test_reset_abort();
        int pulses;
        int lat;
        set_in(8'h11, 8'h22, 8'h33, 0, 0, 0, 0, 0, 0, 2'b01);
        fire_ce();
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (bus.AUDIO_VALID) pulses++;
        end
        vectors++;
        if (bus.AUDIO_L !== 16'sd0 || bus.AUDIO_R !== 16'sd0 ||
            bus.OVERRUN !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_reset got L=%0d R=%0d ovr=%b want 0 0 0",
                     bus.AUDIO_L, bus.AUDIO_R, bus.OVERRUN);
        end
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (bus.AUDIO_VALID) pulses++;
        end
        vectors++;
        if (pulses !== 0) begin
            miscompares++;
            $display("FAIL abort_no_valid got %0d pulses want 0", pulses);
        end
        set_in(8'hFF, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01);
        fire_ce();
        wait_valid(lat);
        vectors++;
        if (lat !== LAT || bus.AUDIO_L !== 16'sd4080 || bus.AUDIO_R !== 16'sd0) begin
            miscompares++;
            $display("FAIL after_abort got lat=%0d L=%0d R=%0d want %0d 4080 0",
                     lat, bus.AUDIO_L, bus.AUDIO_R, LAT);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bus.CE      = 1'b0;
        test_reset();
        test_abc_a0();
        test_routing();
        test_fm();
        test_snapshot_hold();
        test_back_to_back();
        test_overrun();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ts_mixer.md
TS_MIXER -- requirements
Module: ts_mixer

Interface
REQ-001 SHALL have port CLK  in  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port RESET  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port CE  in  1  sample strobe, one-CLK pulse requesting a new mix.
REQ-004 SHALL have ports SSG0_AUDIO_A/B/C, SSG1_AUDIO_A/B/C  in  8 each  unsigned PSG channel levels.
REQ-005 SHALL have ports SSG0_AUDIO_FM, SSG1_AUDIO_FM  in  16 each  signed two's-complement FM samples.
REQ-006 SHALL have port SSG_FM_ENA  in  1  FM contribution enable.
REQ-007 SHALL have port STEREO  in  2  00 mono, 01 ABC, 10 ACB, 11 treated as ABC.
REQ-008 SHALL have ports AUDIO_L, AUDIO_R  out  16 each  signed mixed output, registered.
REQ-009 SHALL have port AUDIO_VALID  out  1  one-CLK pulse when AUDIO_L/R update.
REQ-010 SHALL have port OVERRUN  out  1  sticky flag, CE received while busy.

Function
REQ-011 SHALL implement states IDLE, ACC, OUT; CE is acted on only in IDLE.
REQ-012 In IDLE with CE=1 at edge k, SHALL snapshot all audio inputs, SSG_FM_ENA and STEREO, clear 18-bit signed accumulators ACC_L/ACC_R, set step=0, enter ACC.
REQ-013 In ACC, SHALL add exactly one term per edge in order: A0, B0, C0, A1, B1, C1, FM0, FM1 (steps 0..7), then enter OUT.
REQ-014 PSG full weight = level zero-extended <<4; half weight = level <<3.
REQ-015 ABC: A full->L; B half->L and R; C full->R. ACB: A full->L; C half->L and R; B full->R. Mono: A, B, C half->both.
REQ-016 FM step: if snapshotted SSG_FM_ENA=1, SHALL add FM sample arithmetic-shifted right by 1, sign-extended, to both L and R; else add 0.
REQ-017 In OUT (edge k+9), SHALL load AUDIO_L/R with ACC_L/R saturated to [-32768, 32767], assert AUDIO_VALID for exactly one cycle, return to IDLE.
REQ-018 Latency: CE at edge k -> new outputs and AUDIO_VALID=1 after edge k+9; next CE accepted at edge k+10.
REQ-019 CE in ACC or OUT SHALL be ignored for mixing and SHALL set OVERRUN=1; OVERRUN clears only on RESET.
REQ-020 Input changes after the snapshot edge SHALL NOT affect the in-progress result.
REQ-021 AUDIO_L/R SHALL hold their last value between VALID pulses.

Reset
REQ-022 RESET SHALL asynchronously force state IDLE, step=0, ACC_L=ACC_R=0, AUDIO_L=AUDIO_R=0, AUDIO_VALID=0, OVERRUN=0.
REQ-023 RESET mid-operation SHALL abort the mix with no AUDIO_VALID pulse; the first CE after RESET deasserts starts a fresh mix.

Configuration
REQ-024 Macro TS_MIXER_FM_EN defined: FM steps 6-7 present, latency 9 cycles per REQ-018.
REQ-025 TS_MIXER_FM_EN undefined: FM inputs and SSG_FM_ENA ignored, ACC has steps 0..5 only, OUT at edge k+7, next CE accepted at edge k+8; OVERRUN window shrinks accordingly.

Verification
REQ-026 ABC, A0=0xFF, others 0, FM_ENA=0, CE pulse -> AUDIO_L=4080, AUDIO_R=0, VALID exactly 9 cycles after CE edge.
REQ-027 ABC, B0=0x80 only -> L=R=1024; mono, A0=0x10 only -> L=R=128.
REQ-028 ABC, FM_ENA=1, FM0=FM1=0x7FFF, A0=A1=0xFF -> L=32767 (saturated from 40926), R=32766.
REQ-029 FM_ENA=1, FM0=FM1=0x8000, PSG all 0 -> L=R=-32768; FM_ENA=0 same inputs -> L=R=0.
REQ-030 CE at edges k and k+4 -> single VALID at k+9 with result of k snapshot, OVERRUN=1 until RESET.
REQ-031 CE at k, RESET asserted at k+5 -> outputs 0, no VALID; CE after release -> normal result 9 cycles later.
